// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM. Sequences the shared datapath (PC, IR,
// register file, single ALU, unified memory port) from the latched
// instruction, the ALU EQ flag and the memory ready handshake. Illegal
// encodings and memory stalls halt the machine with sticky error flags.
module multicycle_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  eq,
  input  logic                  mem_ready,
  output logic                  pc_we,
  output logic                  ir_we,
  output logic                  reg_we,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  addr_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [2:0]            alu_ctrl,
  output logic [1:0]            result_src,
  output logic [2:0]            imm_src,
  output logic [3:0]            state,
  output logic                  illegal,
  output logic                  timeout
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_HALT     = 4'd15
  } state_t;

  state_t           cur_state;
  state_t           nxt_state;
  logic [CNT_W-1:0] wait_cnt;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       is_load, is_store, is_rtype, is_itype, is_branch, is_jal, is_lui;
  logic       dec_illegal;
  logic [2:0] dec_alu;
  logic       wait_state;
  logic       tmo_hit;

  // Fields outside opcode/funct3/funct7[5] belong to the datapath only.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[DATA_WIDTH-1:31], instr[29:15], instr[11:7]};

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7_b5 = instr[30];

  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_rtype  = (opcode == OP_RTYPE);
  assign is_itype  = (opcode == OP_ITYPE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_lui    = (opcode == OP_LUI);

  // Unknown opcodes, SLTU/LD/SD style funct3 011, arithmetic right shifts
  // and branch kinds other than BEQ/BNE are all unsupported.
  assign dec_illegal =
      !(is_load || is_store || is_rtype || is_itype || is_branch || is_jal || is_lui)
    || ((is_load || is_store || is_rtype || is_itype) && (funct3 == 3'b011))
    || ((is_rtype || is_itype) && (funct3 == 3'b101) && funct7_b5)
    || (is_branch && (funct3[2:1] != 2'b00));

  assign wait_state = (cur_state == S_FETCH) || (cur_state == S_MEMREAD) ||
                      (cur_state == S_MEMWRITE);
  // A ready in the final allowed cycle still completes the transfer.
  assign tmo_hit    = wait_state && !mem_ready && (wait_cnt == CNT_MAX);

  assign state = cur_state;

  // Immediate format selected from the opcode in every state.
  always_comb begin
    imm_src = 3'b000;
    if (is_store)       imm_src = 3'b001;
    else if (is_branch) imm_src = 3'b010;
    else if (is_jal)    imm_src = 3'b011;
    else if (is_lui)    imm_src = 3'b100;
  end

  // ALU operation for EXECR/EXECI derived from funct3 (and funct7[5] for SUB).
  always_comb begin
    dec_alu = ALU_ADD;
    case (funct3)
      3'b000:  dec_alu = (is_rtype && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b111:  dec_alu = ALU_AND;
      3'b110:  dec_alu = ALU_OR;
      3'b100:  dec_alu = ALU_XOR;
      3'b010:  dec_alu = ALU_SLT;
      3'b001:  dec_alu = ALU_SLL;
      3'b101:  dec_alu = ALU_SRL;
      default: dec_alu = ALU_ADD;
    endcase
  end

  // Next-state selection; a memory stall timeout overrides everything.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_FETCH:    if (mem_ready) nxt_state = S_DECODE;
      S_DECODE: begin
        if (dec_illegal)                nxt_state = S_HALT;
        else if (is_load || is_store)   nxt_state = S_MEMADR;
        else if (is_rtype)              nxt_state = S_EXECR;
        else if (is_itype)              nxt_state = S_EXECI;
        else if (is_branch)             nxt_state = S_BRANCH;
        else if (is_jal)                nxt_state = S_JAL;
        else                            nxt_state = S_LUI;
      end
      S_MEMADR:   nxt_state = is_store ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) nxt_state = S_MEMWB;
      S_MEMWB:    nxt_state = S_FETCH;
      S_MEMWRITE: if (mem_ready) nxt_state = S_FETCH;
      S_EXECR:    nxt_state = S_ALUWB;
      S_EXECI:    nxt_state = S_ALUWB;
      S_ALUWB:    nxt_state = S_FETCH;
      S_BRANCH:   nxt_state = S_FETCH;
      S_JAL:      nxt_state = S_ALUWB;
      S_LUI:      nxt_state = S_ALUWB;
      S_HALT:     nxt_state = S_HALT;
      default:    nxt_state = S_HALT;
    endcase
    if (tmo_hit) nxt_state = S_HALT;
  end

  // State register, memory wait counter and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state <= S_FETCH;
      wait_cnt  <= '0;
      illegal   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (wait_state && !mem_ready && (nxt_state == cur_state))
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      if ((cur_state == S_DECODE) && dec_illegal) illegal <= 1'b1;
      if (tmo_hit)                                timeout <= 1'b1;
    end
  end

  // Control outputs decode from the registered state so mem_ready and eq
  // act in the same cycle; enables are also gated by reset so an
  // in-flight request drops as soon as reset asserts.
  always_comb begin
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_src   = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_ctrl   = ALU_ADD;
    result_src = 2'b00;
    case (cur_state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_we      = mem_ready;
        ir_we      = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem_req  = 1'b1;
        addr_src = 1'b1;
      end
      S_MEMWB: begin
        reg_we     = 1'b1;
        result_src = 2'b01;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_src = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_ctrl  = dec_alu;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_ctrl  = dec_alu;
      end
      S_ALUWB: reg_we = 1'b1;
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_ctrl  = ALU_SUB;
        pc_we     = funct3[0] ? ~eq : eq;
      end
      S_JAL: begin
        pc_we     = 1'b1;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
      end
      default: ;
    endcase
    if (!rst) begin
      pc_we   = 1'b0;
      ir_we   = 1'b0;
      reg_we  = 1'b0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: per-cycle expected control vectors are
// queued alongside their stimulus and compared as the FSM steps.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        eq;
  logic        mem_ready;
  logic        pc_we, ir_we, reg_we, mem_req, mem_we, addr_src;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [2:0]  alu_ctrl, imm_src;
  logic [3:0]  state;
  logic        illegal, timeout;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00000463;
  localparam logic [31:0] I_BNE  = 32'h00001463;
  localparam logic [31:0] I_SUB  = 32'h40208033;
  localparam logic [31:0] I_SRA  = 32'h40205033;
  localparam logic [31:0] I_JAL  = 32'h0040006F;
  localparam logic [31:0] I_LUI  = 32'h123450B7;

  localparam logic [2:0] IM_I = 3'b000;
  localparam logic [2:0] IM_S = 3'b001;
  localparam logic [2:0] IM_B = 3'b010;
  localparam logic [2:0] IM_J = 3'b011;
  localparam logic [2:0] IM_U = 3'b100;

  multicycle_ctrl #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .instr(instr), .eq(eq), .mem_ready(mem_ready),
    .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we), .mem_req(mem_req),
    .mem_we(mem_we), .addr_src(addr_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .result_src(result_src),
    .imm_src(imm_src), .state(state), .illegal(illegal), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   passes = 0;
  logic e_ill  = 1'b0;
  logic e_to   = 1'b0;

  typedef struct {
    logic [31:0] ins;
    logic        rdy;
    logic        eqv;
    logic [23:0] exp;
  } step_t;
  step_t sb[$];

  // Expected vector: {state, pc_we,ir_we,reg_we,mem_req,mem_we, addr_src,
  // a, b, alu, result_src, imm_src, illegal, timeout}
  function automatic logic [23:0] v(input logic [3:0] st, input logic [4:0] en,
                                    input logic as, input logic [1:0] a,
                                    input logic [1:0] b, input logic [2:0] alu,
                                    input logic [1:0] rs, input logic [2:0] imm);
    return {st, en, as, a, b, alu, rs, imm, e_ill, e_to};
  endfunction

  function automatic logic [23:0] obs();
    return {state, pc_we, ir_we, reg_we, mem_req, mem_we, addr_src, alu_src_a,
            alu_src_b, alu_ctrl, result_src, imm_src, illegal, timeout};
  endfunction

  function automatic logic [23:0] fetch_v(input logic [2:0] imm, input logic rdy);
    return v(4'd0, rdy ? 5'b11010 : 5'b00010, 1'b0, 2'b00, 2'b10, 3'b000, 2'b10, imm);
  endfunction
  function automatic logic [23:0] decode_v(input logic [2:0] imm);
    return v(4'd1, 5'b00000, 1'b0, 2'b01, 2'b01, 3'b000, 2'b00, imm);
  endfunction
  function automatic logic [23:0] aluwb_v(input logic [2:0] imm);
    return v(4'd8, 5'b00100, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00, imm);
  endfunction
  function automatic logic [23:0] memadr_v(input logic [2:0] imm);
    return v(4'd2, 5'b00000, 1'b0, 2'b10, 2'b01, 3'b000, 2'b00, imm);
  endfunction
  function automatic logic [23:0] halt_v(input logic [2:0] imm);
    return v(4'd15, 5'b00000, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00, imm);
  endfunction

  task automatic push(input logic [31:0] ins, input logic rdy, input logic eqv,
                      input logic [23:0] exp);
    step_t s;
    s.ins = ins; s.rdy = rdy; s.eqv = eqv; s.exp = exp;
    sb.push_back(s);
  endtask

  task automatic apply_reset();
    rst = 1'b0; mem_ready = 1'b0; eq = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    e_ill = 1'b0; e_to = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_ready = 1'b1; eq = 1'b1; instr = I_ADDI;
    @(negedge clk);
    checks++;
    if (state !== 4'd0) $display("FAIL reset_state: got %0d expected 0", state);
    else passes++;
    checks++;
    if ({pc_we, ir_we, reg_we, mem_req, mem_we} !== 5'b00000)
      $display("FAIL reset_enables: got %b expected 00000", {pc_we, ir_we, reg_we, mem_req, mem_we});
    else passes++;
    checks++;
    if ({illegal, timeout} !== 2'b00)
      $display("FAIL reset_flags: got %b expected 00", {illegal, timeout});
    else passes++;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_alu();
    int n = 0;
    push(I_ADDI, 1, 0, fetch_v(IM_I, 1));
    push(I_ADDI, 1, 0, decode_v(IM_I));
    push(I_ADDI, 1, 0, v(4'd7, 5'b00000, 1'b0, 2'b10, 2'b01, 3'b000, 2'b00, IM_I));
    push(I_ADDI, 1, 0, aluwb_v(IM_I));
    push(I_SUB, 1, 0, fetch_v(IM_I, 1));
    push(I_SUB, 1, 0, decode_v(IM_I));
    push(I_SUB, 1, 0, v(4'd6, 5'b00000, 1'b0, 2'b10, 2'b00, 3'b001, 2'b00, IM_I));
    push(I_SUB, 1, 0, aluwb_v(IM_I));
    push(I_LUI, 1, 0, fetch_v(IM_U, 1));
    push(I_LUI, 1, 0, decode_v(IM_U));
    push(I_LUI, 1, 0, v(4'd11, 5'b00000, 1'b0, 2'b11, 2'b01, 3'b000, 2'b00, IM_U));
    push(I_LUI, 1, 0, aluwb_v(IM_U));
    push(I_JAL, 1, 0, fetch_v(IM_J, 1));
    push(I_JAL, 1, 0, decode_v(IM_J));
    push(I_JAL, 1, 0, v(4'd10, 5'b10000, 1'b0, 2'b01, 2'b10, 3'b000, 2'b00, IM_J));
    push(I_JAL, 1, 0, aluwb_v(IM_J));
    while (sb.size() != 0) begin
      step_t s;
      s = sb.pop_front();
      instr = s.ins; mem_ready = s.rdy; eq = s.eqv;
      @(negedge clk);
      checks++;
      if (obs() !== s.exp) $display("FAIL alu step %0d: got %h expected %h", n, obs(), s.exp);
      else passes++;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_memory();
    int n = 0;
    push(I_LW, 1, 0, fetch_v(IM_I, 1));
    push(I_LW, 1, 0, decode_v(IM_I));
    push(I_LW, 1, 0, memadr_v(IM_I));
    for (int i = 0; i < 4; i++)
      push(I_LW, (i == 3), 0, v(4'd3, 5'b00010, 1'b1, 2'b00, 2'b00, 3'b000, 2'b00, IM_I));
    push(I_LW, 1, 0, v(4'd4, 5'b00100, 1'b0, 2'b00, 2'b00, 3'b000, 2'b01, IM_I));
    push(I_SW, 1, 0, fetch_v(IM_S, 1));
    push(I_SW, 1, 0, decode_v(IM_S));
    push(I_SW, 1, 0, memadr_v(IM_S));
    push(I_SW, 1, 0, v(4'd5, 5'b00011, 1'b1, 2'b00, 2'b00, 3'b000, 2'b00, IM_S));
    push(I_ADDI, 1, 0, fetch_v(IM_I, 1));
    while (sb.size() != 0) begin
      step_t s;
      s = sb.pop_front();
      instr = s.ins; mem_ready = s.rdy; eq = s.eqv;
      @(negedge clk);
      checks++;
      if (obs() !== s.exp) $display("FAIL memory step %0d: got %h expected %h", n, obs(), s.exp);
      else passes++;
      n++;
      @(posedge clk); #1;
    end
    // finish the addi whose fetch closed the sequence above
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_branch();
    int n = 0;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] ins;
      logic        e;
      logic        take;
      ins  = (k < 2) ? I_BEQ : I_BNE;
      e    = (k % 2 == 0);
      take = (k < 2) ? e : !e;
      push(ins, 1, e, fetch_v(IM_B, 1));
      push(ins, 1, e, decode_v(IM_B));
      push(ins, 1, e, v(4'd9, take ? 5'b10000 : 5'b00000, 1'b0, 2'b10, 2'b00, 3'b001, 2'b00, IM_B));
    end
    while (sb.size() != 0) begin
      step_t s;
      s = sb.pop_front();
      instr = s.ins; mem_ready = s.rdy; eq = s.eqv;
      @(negedge clk);
      checks++;
      if (obs() !== s.exp) $display("FAIL branch step %0d: got %h expected %h", n, obs(), s.exp);
      else passes++;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wait_boundary();
    int n = 0;
    for (int i = 0; i < 8; i++) push(I_ADDI, 0, 0, fetch_v(IM_I, 0));
    push(I_ADDI, 1, 0, fetch_v(IM_I, 1));
    push(I_ADDI, 1, 0, decode_v(IM_I));
    push(I_ADDI, 1, 0, v(4'd7, 5'b00000, 1'b0, 2'b10, 2'b01, 3'b000, 2'b00, IM_I));
    push(I_ADDI, 1, 0, aluwb_v(IM_I));
    while (sb.size() != 0) begin
      step_t s;
      s = sb.pop_front();
      instr = s.ins; mem_ready = s.rdy; eq = s.eqv;
      @(negedge clk);
      checks++;
      if (obs() !== s.exp) $display("FAIL wait_boundary step %0d: got %h expected %h", n, obs(), s.exp);
      else passes++;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_write();
    int n = 0;
    push(I_SW, 1, 0, fetch_v(IM_S, 1));
    push(I_SW, 1, 0, decode_v(IM_S));
    push(I_SW, 1, 0, memadr_v(IM_S));
    push(I_SW, 0, 0, v(4'd5, 5'b00011, 1'b1, 2'b00, 2'b00, 3'b000, 2'b00, IM_S));
    while (sb.size() != 0) begin
      step_t s;
      s = sb.pop_front();
      instr = s.ins; mem_ready = s.rdy; eq = s.eqv;
      @(negedge clk);
      checks++;
      if (obs() !== s.exp) $display("FAIL mid_write step %0d: got %h expected %h", n, obs(), s.exp);
      else passes++;
      n++;
      @(posedge clk); #1;
    end
    #2;
    checks++;
    if ({state, mem_req, mem_we} !== {4'd5, 2'b11})
      $display("FAIL mid_write_pre: got %h expected %h", {state, mem_req, mem_we}, {4'd5, 2'b11});
    else passes++;
    rst = 1'b0;
    #1;
    checks++;
    if ({state, pc_we, ir_we, reg_we, mem_req, mem_we} !== {4'd0, 5'b00000})
      $display("FAIL mid_write_drop: got %h expected %h",
               {state, pc_we, ir_we, reg_we, mem_req, mem_we}, {4'd0, 5'b00000});
    else passes++;
    @(posedge clk); #1;
    rst = 1'b1; mem_ready = 1'b0; instr = I_ADDI;
    @(negedge clk);
    checks++;
    if ({state, mem_req} !== {4'd0, 1'b1})
      $display("FAIL mid_write_refetch: got %h expected %h", {state, mem_req}, {4'd0, 1'b1});
    else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    int n = 0;
    apply_reset();
    push(I_SRA, 1, 0, fetch_v(IM_I, 1));
    push(I_SRA, 1, 0, decode_v(IM_I));
    e_ill = 1'b1;
    push(I_SRA, 1, 0, halt_v(IM_I));
    push(I_SRA, 1, 0, halt_v(IM_I));
    while (sb.size() != 0) begin
      step_t s;
      s = sb.pop_front();
      instr = s.ins; mem_ready = s.rdy; eq = s.eqv;
      @(negedge clk);
      checks++;
      if (obs() !== s.exp) $display("FAIL illegal step %0d: got %h expected %h", n, obs(), s.exp);
      else passes++;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    apply_reset();
    for (int i = 0; i < 9; i++) push(I_ADDI, 0, 0, fetch_v(IM_I, 0));
    e_to = 1'b1;
    push(I_ADDI, 0, 0, halt_v(IM_I));
    push(I_ADDI, 1, 0, halt_v(IM_I));
    push(I_ADDI, 0, 0, halt_v(IM_I));
    while (sb.size() != 0) begin
      step_t s;
      s = sb.pop_front();
      instr = s.ins; mem_ready = s.rdy; eq = s.eqv;
      @(negedge clk);
      checks++;
      if (obs() !== s.exp) $display("FAIL timeout step %0d: got %h expected %h", n, obs(), s.exp);
      else passes++;
      n++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_memory();
    test_branch();
    test_wait_boundary();
    test_reset_mid_write();
    test_illegal();
    test_timeout();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
